// File: rtl/uart_cmd_rcv.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_rcv
// Description : Receives a 16-bit command as two 8N1 UART bytes, high byte
//               first. It flags framing errors and presents the command with
//               a ready/clear handshake. Optional macro CMD_TMO_EN adds an
//               inter-byte timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_rcv #(
    parameter int BAUD_DIV = 5208,
    parameter int TMO_CYC  = 2000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    input  logic        clr_cmd_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic        frm_err
);

    localparam int c_baud_w = $clog2(BAUD_DIV + 1);
    localparam logic [c_baud_w-1:0] c_baud_full = c_baud_w'(BAUD_DIV);
    localparam logic [c_baud_w-1:0] c_baud_half = c_baud_w'(BAUD_DIV / 2);
    localparam logic [c_baud_w-1:0] c_baud_one  = c_baud_w'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_rx_s1;
    logic                r_rx_s2;
    logic                r_rx_prev;
    logic                w_start_edge;
    logic [c_baud_w-1:0] r_baud;
    logic [c_baud_w-1:0] w_baud_dec;
    logic                w_tick;
    logic [3:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic [7:0]          r_hi_byte;
    logic                r_ptr_lo;
    logic                w_byte_ok;
    logic                w_byte_bad;
    logic                w_tmo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= RX;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    assign w_start_edge = r_rx_prev & ~r_rx_s2;

    // The event fires on the cycle the count would reach zero, so one bit
    // period is exactly BAUD_DIV clocks and the counter never holds zero.
    assign w_baud_dec = r_baud - c_baud_one;
    assign w_tick     = (w_baud_dec == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_byte_ok   = 1'b0;
        w_byte_bad  = 1'b0;
        case (r_state)
            S_IDLE:  if (w_start_edge) w_state_nxt = S_START;
            S_START: if (w_tick) w_state_nxt = r_rx_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (w_tick && (r_bit_cnt == 4'd7)) w_state_nxt = S_STOP;
            S_STOP: begin
                if (w_tick) begin
                    w_state_nxt = S_IDLE;
                    w_byte_ok   = r_rx_s2;
                    w_byte_bad  = ~r_rx_s2;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud    <= c_baud_full;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'h00;
        end else begin
            if (w_state_nxt != r_state) begin
                r_baud <= (w_state_nxt == S_START) ? c_baud_half : c_baud_full;
            end else if ((r_state == S_DATA) && w_tick) begin
                r_baud <= c_baud_full;
            end else if (r_state != S_IDLE) begin
                r_baud <= w_baud_dec;
            end

            if (r_state == S_START) begin
                r_bit_cnt <= 4'd0;
            end else if ((r_state == S_DATA) && w_tick) begin
                r_shift   <= {r_rx_s2, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd       <= 16'h0000;
            cmd_rdy   <= 1'b0;
            frm_err   <= 1'b0;
            r_hi_byte <= 8'h00;
            r_ptr_lo  <= 1'b0;
        end else begin
            frm_err <= w_byte_bad;

            // A completing command outranks a simultaneous clear.
            if (w_byte_ok && r_ptr_lo) begin
                cmd     <= {r_hi_byte, r_shift};
                cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end

            if (w_byte_bad || w_tmo) begin
                r_ptr_lo <= 1'b0;
            end else if (w_byte_ok) begin
                if (!r_ptr_lo) r_hi_byte <= r_shift;
                r_ptr_lo <= ~r_ptr_lo;
            end
        end
    end

`ifdef CMD_TMO_EN
    localparam int c_tmo_w = $clog2(TMO_CYC + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_lim = c_tmo_w'(TMO_CYC);

    logic [c_tmo_w-1:0] r_tmo_cnt;

    // Counts only while idle with a high byte pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (!r_ptr_lo || w_start_edge || (r_state != S_IDLE)) begin
            r_tmo_cnt <= '0;
        end else if (r_tmo_cnt != c_tmo_lim) begin
            r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
        end
    end

    assign w_tmo = r_ptr_lo && (r_state == S_IDLE) && !w_start_edge &&
                   (r_tmo_cnt == c_tmo_lim);
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TMO_CYC != 0);
    assign w_tmo        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_rcv.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_rcv
// Description : Scoreboard bench for uart_cmd_rcv with bit-banged UART frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_rcv;

    localparam int BAUD = 16;
    localparam int TMO  = 1000;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b0;
    logic        RX          = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        frm_err;

    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          exp_frm  = 0;
    int          seen_frm = 0;
    int          stop_cyc = 0;
    logic [15:0] exp_q[$];
    bit          have_hi  = 1'b0;
    logic [7:0]  hi_b     = 8'h00;
    logic        prev_rdy = 1'b0;
    logic        prev_frm = 1'b0;
    logic [15:0] prev_cmd = 16'h0000;
    logic [15:0] mon_exp;
    int          lat;

    uart_cmd_rcv #(.BAUD_DIV(BAUD), .TMO_CYC(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .frm_err     (frm_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    // Byte-level protocol model: pair good bytes high-then-low, a bad byte restarts pairing.
    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            have_hi = 1'b0;
            exp_frm++;
        end else if (!have_hi) begin
            hi_b    = b;
            have_hi = 1'b1;
        end else begin
            exp_q.push_back({hi_b, b});
            have_hi = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad, input bit clr_stop);
        model_byte(b, !bad);
        @(negedge clk);
        RX = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BAUD) @(negedge clk);
        end
        RX       = bad ? 1'b0 : 1'b1;
        stop_cyc = cyc;
        if (clr_stop) clr_cmd_rdy = 1'b1;
        repeat (BAUD) @(negedge clk);
        RX          = 1'b1;
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic send_cmd(input logic [15:0] c);
        send_byte(c[15:8], 1'b0, 1'b0);
        send_byte(c[7:0], 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
`ifdef CMD_TMO_EN
        if (n >= TMO) have_hi = 1'b0;
`endif
    endtask

    task automatic clear_check(input string nm);
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check(nm, {15'd0, cmd_rdy}, 16'd0);
    endtask

    // Monitor: every new presentation of a command pops one expected value.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_rdy && (!prev_rdy || (cmd != prev_cmd))) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_cmd got %h expected none", cmd);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (cmd !== mon_exp) begin
                        errors++;
                        $display("FAIL cmd_value got %h expected %h", cmd, mon_exp);
                    end
                    checks++;
                    lat = cyc - stop_cyc;
                    if (lat < 8 || lat > 14) begin
                        errors++;
                        $display("FAIL cmd_rdy_latency got %0d expected 8..14 clk after stop bit start", lat);
                    end
                end
            end
            if (frm_err) begin
                seen_frm++;
                if (prev_frm) begin
                    checks++;
                    errors++;
                    $display("FAIL frm_err_width got >1 expected 1 clk");
                end
            end
        end
        prev_rdy = cmd_rdy;
        prev_cmd = cmd;
        prev_frm = frm_err;
    end

    initial begin
        logic [15:0] c;
        bit          bh;
        bit          bl;

        repeat (3) @(negedge clk);
        check("reset_cmd", cmd, 16'h0000);
        check("reset_cmd_rdy", {15'd0, cmd_rdy}, 16'd0);
        check("reset_frm_err", {15'd0, frm_err}, 16'd0);
        rst_n = 1'b1;
        idle(5);

        send_cmd(16'h5555);
        idle(4);
        clear_check("clear_5555");

        send_cmd(16'h002D);
        idle(4);
        send_cmd(16'hFFFF);
        idle(4);
        check("overwrite_rdy", {15'd0, cmd_rdy}, 16'd1);
        check("overwrite_cmd", cmd, 16'hFFFF);
        clear_check("clear_ffff");

        send_byte(8'h3C, 1'b1, 1'b0);
        idle(4);
        send_cmd(16'hAAAA);
        idle(4);
        clear_check("clear_aaaa");

        RX = 1'b0;
        repeat (3) @(negedge clk);
        RX = 1'b1;
        idle(30);
        check("glitch_rdy", {15'd0, cmd_rdy}, 16'd0);
        send_cmd(16'h001E);
        idle(4);
        clear_check("clear_001e");

        send_byte(8'h5A, 1'b0, 1'b0);
        send_byte(8'hC3, 1'b0, 1'b1);
        idle(2);
        check("same_cycle_cmd", cmd, 16'h5AC3);
        check("clear_after_set", {15'd0, cmd_rdy}, 16'd0);

        send_byte(8'h12, 1'b0, 1'b0);
        RX = 1'b0;
        repeat (40) @(negedge clk);
        rst_n   = 1'b0;
        have_hi = 1'b0;
        repeat (2) @(negedge clk);
        RX = 1'b1;
        check("midframe_reset_cmd", cmd, 16'h0000);
        check("midframe_reset_rdy", {15'd0, cmd_rdy}, 16'd0);
        rst_n = 1'b1;
        idle(5);
        send_cmd(16'h00FF);
        idle(4);
        check("after_reset_cmd", cmd, 16'h00FF);
        clear_check("clear_00ff");

        for (int k = 0; k < 14; k++) begin
            c  = 16'($urandom);
            bh = ($urandom_range(0, 7) == 0);
            bl = ($urandom_range(0, 7) == 0);
            send_byte(c[15:8], bh, 1'b0);
            idle(3);
            if (cmd_rdy) clear_check("clear_rand_hi");
            idle($urandom_range(0, 30));
            send_byte(c[7:0], bl, 1'b0);
            idle(3);
            if (cmd_rdy) clear_check("clear_rand_lo");
        end

        // Realign the receiver and model on a byte boundary before the timeout case.
        send_byte(8'h00, 1'b1, 1'b0);
        idle(4);
        send_byte(8'h12, 1'b0, 1'b0);
        idle(1200);
        send_byte(8'hAB, 1'b0, 1'b0);
        send_byte(8'hCD, 1'b0, 1'b0);
        idle(4);
`ifdef CMD_TMO_EN
        check("timeout_cmd", cmd, 16'hABCD);
`else
        check("timeout_cmd", cmd, 16'h12AB);
`endif
        idle(20);

        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        check("frm_err_count", 16'(seen_frm), 16'(exp_frm));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
